trng_ctrl: RTL and testbench

//  Sequencer for the ring-oscillator entropy source. Enables the oscillator, waits out

---
 rtl/trng_pkg.sv | 22 ++
 rtl/trng_if.sv | 11 +
 rtl/sync_2ff.sv | 18 +
 rtl/trng_ctrl.sv | 176 +++++++++++++++++
 tb/tb_trng_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared types and defaults for the ring-oscillator TRNG sequencer.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_SAMPLE,
        ST_HOLD,
        ST_FAIL
    } state_e;

    localparam int DEF_WARMUP_CYC = 64;
    localparam int DEF_SAMPLE_DIV = 8;
    localparam int DEF_RCT_LIMIT  = 32;
    localparam int BYTE_W         = 8;

    // Von Neumann pair: {accept, bit}; 10 -> 1, 01 -> 0, equal pairs rejected.
    function automatic logic [1:0] vn_debias(input logic first, input logic second);
        return {first ^ second, first};
    endfunction

endpackage

// File: rtl/trng_if.sv
// Byte delivery channel (valid/ready) from the TRNG sequencer to its consumer.
interface trng_if;
    import trng_pkg::*;

    logic [BYTE_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              rnd_ready;

    modport master (output rnd_data, output rnd_valid, input  rnd_ready);
    modport slave  (input  rnd_data, input  rnd_valid, output rnd_ready);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the free-running oscillator output into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG sequencer: warm-up, divided sampling, Von Neumann debias,
// repetition-count health test and valid/ready byte delivery.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int WARMUP_CYC = DEF_WARMUP_CYC,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int RCT_LIMIT  = DEF_RCT_LIMIT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          ro_in,
    output logic          ro_activate,
    output logic          health_fail,
    output logic          busy,
    trng_if.master        rnd
);

    localparam int WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int TICK_W = $clog2(SAMPLE_DIV + 1);
    localparam int RCT_W  = $clog2(RCT_LIMIT + 1);
    localparam int CNT_W  = $clog2(BYTE_W + 1);

    state_e              state_q;
    logic [WARM_W-1:0]   warm_q;
    logic [TICK_W-1:0]   tick_q;
    logic [RCT_W-1:0]    rct_q;
    logic [CNT_W-1:0]    nbits_q;
    logic [BYTE_W-1:0]   part_q, park_q, data_q;
    logic                last_raw_q, have_first_q, first_q;
    logic                valid_q, act_q, fail_q, busy_q;

    logic                ro_s;
    logic                sample_now, rct_trip, take, byte_done;
    logic [1:0]          vn;
    logic [RCT_W-1:0]    rct_d;
    logic [BYTE_W-1:0]   byte_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ro_in),
        .q_o   (ro_s)
    );

    assign take       = valid_q & rnd.rnd_ready;
    assign sample_now = (state_q == ST_SAMPLE) && (tick_q == TICK_W'(SAMPLE_DIV - 1));
    // rct_q == 0 marks "no sample yet in this run", so the first sample starts a run of 1.
    assign rct_d      = (rct_q == '0 || ro_s != last_raw_q) ? RCT_W'(1) : rct_q + RCT_W'(1);
    assign rct_trip   = sample_now && (rct_d == RCT_W'(RCT_LIMIT));
    assign vn         = vn_debias(first_q, ro_s);
    assign byte_d     = {part_q[BYTE_W-2:0], vn[0]};
    assign byte_done  = vn[1] && (nbits_q == CNT_W'(BYTE_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            warm_q       <= '0;
            tick_q       <= '0;
            rct_q        <= '0;
            nbits_q      <= '0;
            part_q       <= '0;
            park_q       <= '0;
            data_q       <= '0;
            last_raw_q   <= 1'b0;
            have_first_q <= 1'b0;
            first_q      <= 1'b0;
            valid_q      <= 1'b0;
            act_q        <= 1'b0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            if (take) valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Scrubbing here discards partial/parked bytes from any aborted run.
                    warm_q       <= '0;
                    tick_q       <= '0;
                    rct_q        <= '0;
                    nbits_q      <= '0;
                    part_q       <= '0;
                    park_q       <= '0;
                    have_first_q <= 1'b0;
                    first_q      <= 1'b0;
                    last_raw_q   <= 1'b0;
                    if (start) begin
                        state_q <= ST_WARMUP;
                        act_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WARMUP: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (warm_q == WARM_W'(WARMUP_CYC - 1)) begin
                        state_q <= ST_SAMPLE;
                    end else begin
                        warm_q <= warm_q + WARM_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        tick_q <= sample_now ? '0 : tick_q + TICK_W'(1);
                        if (sample_now) begin
                            last_raw_q <= ro_s;
                            rct_q      <= rct_d;
                            if (rct_trip) begin
                                state_q <= ST_FAIL;
                                fail_q  <= 1'b1;
                                act_q   <= 1'b0;
                                valid_q <= 1'b0;
                            end else if (!have_first_q) begin
                                have_first_q <= 1'b1;
                                first_q      <= ro_s;
                            end else begin
                                have_first_q <= 1'b0;
                                if (byte_done) begin
                                    nbits_q <= '0;
                                    part_q  <= '0;
                                    if (!valid_q || take) begin
                                        data_q  <= byte_d;
                                        valid_q <= 1'b1;
                                    end else begin
                                        park_q  <= byte_d;
                                        state_q <= ST_HOLD;
                                    end
                                end else if (vn[1]) begin
                                    part_q  <= byte_d;
                                    nbits_q <= nbits_q + CNT_W'(1);
                                end
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (!start) begin
                        state_q <= ST_IDLE;
                        act_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (take) begin
                        data_q  <= park_q;
                        valid_q <= 1'b1;
                        state_q <= ST_SAMPLE;
                    end
                end
                ST_FAIL: begin
                    valid_q <= 1'b0;
                    if (!start) begin
                        state_q <= ST_IDLE;
                        fail_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    act_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ro_activate   = act_q;
    assign health_fail   = fail_q;
    assign busy          = busy_q;
    assign rnd.rnd_data  = data_q;
    assign rnd.rnd_valid = valid_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed and scoreboarded bench for trng_ctrl with default parameters.
module tb_trng_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, ro_in;
    logic ro_activate, health_fail, busy;
    int   n_tests = 0;
    int   n_fail  = 0;

    trng_if rif ();

    trng_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ro_in       (ro_in),
        .ro_activate (ro_activate),
        .health_fail (health_fail),
        .busy        (busy),
        .rnd         (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] raw;
        int          nraw;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Raise start, then present q[k] so it is the value seen at raw sample k.
    // Sample k lands on edge 72+8k after the start edge; returns #1 after the last one.
    task automatic run_raw(input bit q[$]);
        @(negedge clk);
        ro_in = q[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("ro_activate_rise", ro_activate, 1);
        repeat (72) @(posedge clk);
        for (int k = 1; k < q.size(); k++) begin
            #1 ro_in = q[k];
            repeat (8) @(posedge clk);
        end
        #1;
    endtask

    task automatic stop_run();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_byte();
        @(negedge clk);
        rif.rnd_ready = 1'b1;
        @(posedge clk);
        #1;
        rif.rnd_ready = 1'b0;
    endtask

    function automatic void to_q(input logic [63:0] raw, input int n, output bit q[$]);
        q = {};
        for (int i = n - 1; i >= 0; i--) q.push_back(raw[i]);
    endfunction

    initial begin
        bit         q[$];
        logic [7:0] expq[$];
        int         got, lowrun, drops, nexp;

        // Bytes in hex: 10 -> 1, 01 -> 0, 00/11 discarded.
        vecs[0] = '{64'h9966,      16, 8'hA5};
        vecs[1] = '{64'hC5AA5,     20, 8'h3C};
        vecs[2] = '{64'h5555,      16, 8'h00};
        vecs[3] = '{64'hAAAA,      16, 8'hFF};
        vecs[4] = '{64'h6AAA,      46, 8'h7F};  // 31 identical zeros: one short of the health limit

        rst_n = 1'b0; start = 1'b0; ro_in = 1'b0; rif.rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_activate", ro_activate, 0);
        chk("rst_valid",    rif.rnd_valid, 0);
        chk("rst_data",     rif.rnd_data, 0);
        chk("rst_hfail",    health_fail, 0);
        chk("rst_busy",     busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            to_q(vecs[v].raw, vecs[v].nraw, q);
            run_raw(q);
            chk($sformatf("vec%0d_valid", v), rif.rnd_valid, 1);
            chk($sformatf("vec%0d_data", v),  rif.rnd_data, vecs[v].exp);
            chk($sformatf("vec%0d_busy", v),  busy, 1);
            chk($sformatf("vec%0d_hfail", v), health_fail, 0);
            pop_byte();
            chk($sformatf("vec%0d_drop", v), rif.rnd_valid, 0);
            stop_run();
            chk($sformatf("vec%0d_idle_busy", v), busy, 0);
            chk($sformatf("vec%0d_idle_act", v),  ro_activate, 0);
        end

        // Stuck-at-1 oscillator trips the repetition count on the 32nd sample.
        q = {};
        for (int i = 0; i < 31; i++) q.push_back(1'b1);
        run_raw(q);
        chk("rct31_hfail", health_fail, 0);
        chk("rct31_act",   ro_activate, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("rct32_hfail", health_fail, 1);
        chk("rct32_act",   ro_activate, 0);
        chk("rct32_valid", rif.rnd_valid, 0);
        chk("rct32_busy",  busy, 1);
        stop_run();
        chk("fail_clear_hfail", health_fail, 0);
        chk("fail_clear_busy",  busy, 0);

        // Two bytes with the consumer stalled: first held, second parked.
        to_q(64'h6699A55A, 32, q);
        run_raw(q);
        drops = 0;
        for (int i = 0; i < 20; i++) begin
            if (rif.rnd_valid !== 1'b1 || rif.rnd_data !== 8'h5A) drops++;
            @(posedge clk);
            #1;
        end
        chk("hold_first_stable", drops, 0);
        chk("hold_act", ro_activate, 1);
        pop_byte();
        chk("hold_second_valid", rif.rnd_valid, 1);
        chk("hold_second_data",  rif.rnd_data, 8'hC3);
        pop_byte();
        chk("hold_drain", rif.rnd_valid, 0);
        stop_run();

        // Abort with five 1-bits accepted; the next byte must not contain them.
        to_q(64'h2AA, 10, q);
        run_raw(q);
        chk("abort_novalid", rif.rnd_valid, 0);
        stop_run();
        chk("abort_idle", busy, 0);
        to_q(64'h9966, 16, q);
        run_raw(q);
        chk("abort_next_data", rif.rnd_data, 8'hA5);

        // Async reset between edges, with a byte pending.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",    rif.rnd_valid, 0);
        chk("arst_data",     rif.rnd_data, 0);
        chk("arst_activate", ro_activate, 0);
        chk("arst_busy",     busy, 0);
        chk("arst_hfail",    health_fail, 0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Random raw stream, random ready; runs capped at 20 to stay clear of the health test.
        q = {};
        lowrun = 0;
        for (int i = 0; i < 400; i++) begin
            bit b;
            b = 1'($urandom_range(0, 1));
            if (i > 0 && b == q[i-1] && lowrun >= 20) b = ~b;
            lowrun = (i > 0 && b == q[i-1]) ? lowrun + 1 : 1;
            q.push_back(b);
        end
        expq = {};
        begin
            logic [7:0] acc;
            int         nb;
            acc = '0; nb = 0;
            for (int i = 0; i + 1 < 400; i += 2) begin
                if (q[i] != q[i+1]) begin
                    acc = {acc[6:0], q[i]};
                    nb++;
                    if (nb == 8) begin
                        expq.push_back(acc);
                        nb = 0;
                    end
                end
            end
        end
        nexp = expq.size();
        got = 0;
        fork
            begin
                run_raw(q);
                @(negedge clk);
                start = 1'b0;
            end
            begin
                int lr;
                lr = 0;
                repeat (3600) begin
                    @(negedge clk);
                    rif.rnd_ready = ($urandom_range(0, 1) == 1) || (lr >= 8);
                    lr = rif.rnd_ready ? 0 : lr + 1;
                    if (rif.rnd_valid && rif.rnd_ready) begin
                        got++;
                        if (expq.size() > 0) chk($sformatf("rand_byte%0d", got), rif.rnd_data, expq.pop_front());
                    end
                end
                rif.rnd_ready = 1'b0;
            end
        join
        chk("rand_count", got, nexp);
        chk("rand_end_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
